data_mem_lsu: RTL

Load/store unit that consumes the decoded memory controls (MemRead, byte-enable MemWrite, MemReadSize, MemReadSigned) and executes them against a synchronous single-port data BRAM with 1-cycle read latency. It shifts byte enables and store data to the address byte offset. It extracts and sign- or zero-extends load data, detects misaligned and illegal accesses, and returns a one-cycle response pulse. It sits between the execute stage (address from the ALU ADD result) and the data memory, and stalls the pipeline through req_ready.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/load_formatter.sv | 26 ++
 rtl/data_mem_lsu.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store path.
// Also holds the access classifier used at request accept.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef struct packed {
    logic       is_store;
    logic       is_load;
    logic       fault;
    logic [1:0] size;
  } lsu_class_t;

  // Stores win over loads; size of a store comes from its byte mask.
  function automatic lsu_class_t lsu_classify(input logic       rd,
                                              input logic [3:0] we,
                                              input logic [1:0] rsize,
                                              input logic [1:0] off);
    lsu_class_t c;
    c.is_store = (we != 4'b0000);
    c.is_load  = !c.is_store && rd;
    c.fault    = 1'b0;
    c.size     = rsize;
    if (c.is_store) begin
      case (we)
        BE_B:    c.size = SIZE_B;
        BE_H:    c.size = SIZE_H;
        BE_W:    c.size = SIZE_W;
        default: begin c.size = SIZE_W; c.fault = 1'b1; end
      endcase
    end else if (c.is_load && rsize == 2'd3) begin
      c.fault = 1'b1;
    end
    if ((c.is_store || c.is_load) &&
        ((c.size == SIZE_H && off[0]) || (c.size == SIZE_W && off != 2'd0)))
      c.fault = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts a byte/half/word from a BRAM word and sign- or zero-extends it.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata_i[8*offset_i +: 8];
    h      = rdata_i[16*offset_i[1] +: 16];
    data_o = rdata_i;
    case (size_i)
      SIZE_B:  data_o = {{24{sgn_i & b[7]}}, b};
      SIZE_H:  data_o = {{16{sgn_i & h[15]}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit driving a 1-cycle-latency single-port data BRAM.
// One access in flight; req_ready drops until the response pulse has gone.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic [3:0]        mem_write,
  input  logic [1:0]        mem_read_size,
  input  logic              mem_read_signed,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  lsu_state_t        state_q;
  logic              resp_valid_q, fault_q, ld_q, sgn_q, ram_en_q;
  logic [1:0]        off_q, size_q;
  logic [3:0]        ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q, load_data_q, fmt_d;
  lsu_class_t        cls;
  logic              unused_addr;

  // Address bits above the BRAM range alias (wrap) by design.
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign cls = lsu_classify(mem_read, mem_write, mem_read_size, addr[1:0]);

  load_formatter u_fmt (
    .rdata_i  (ram_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .sgn_i    (sgn_q),
    .data_o   (fmt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      load_data_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ld_q         <= 1'b0;
      sgn_q        <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          if (cls.fault || !(cls.is_store || cls.is_load)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            fault_q      <= cls.fault;
          end else begin
            state_q    <= ISSUE;
            ram_en_q   <= 1'b1;
            ram_addr_q <= addr[ADDR_W+1:2];
            ld_q       <= cls.is_load;
            if (cls.is_store) begin
              ram_we_q    <= mem_write << addr[1:0];
              ram_wdata_q <= store_data << {addr[1:0], 3'b000};
            end else begin
              ram_we_q <= '0;
              off_q    <= addr[1:0];
              size_q   <= cls.size;
              sgn_q    <= mem_read_signed;
            end
          end
        end
        ISSUE: begin
          ram_en_q <= 1'b0;
          ram_we_q <= '0;
          if (ld_q) begin
            state_q <= WAIT;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          load_data_q  <= fmt_d;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign fault      = fault_q;
  assign load_data  = load_data_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule
